// File: rtl/dec_sequencer.sv
// Burst sequencer that drives the dec strobe of a zero-flag downcounter.
// Optional abort input is enabled by defining DEC_SEQ_ABORT_EN.
module dec_sequencer #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [GAP_W-1:0] gap,
  input  logic             zero,
  output logic             dec,
  output logic             busy,
  output logic             done,
  output logic             underflow,
  output logic [LEN_W-1:0] issued
`ifdef DEC_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [LEN_W-1:0]   remaining, remaining_d;
  logic [GAP_W-1:0]   gap_reg, gap_reg_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [LEN_W-1:0]   issued_d;
  logic               underflow_d;
  logic               abort_hit;

`ifdef DEC_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_reg   <= '0;
      gap_cnt   <= '0;
      issued    <= '0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      gap_reg   <= gap_reg_d;
      gap_cnt   <= gap_cnt_d;
      issued    <= issued_d;
      underflow <= underflow_d;
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
    end
  end

  // Next-state, datapath updates and the combinational dec strobe
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    gap_reg_d   = gap_reg;
    gap_cnt_d   = gap_cnt;
    issued_d    = issued;
    underflow_d = underflow;
    dec         = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          remaining_d = len;
          gap_reg_d   = gap;
          issued_d    = '0;
          underflow_d = 1'b0;
          state_d     = (len == '0) ? S_DONE : S_PULSE;
        end
      end

      S_PULSE: begin
        // abort outranks an empty counter in the same cycle
        if (abort_hit) begin
          state_d = S_DONE;
        end else if (zero) begin
          underflow_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          dec         = 1'b1;
          remaining_d = remaining - LEN_W'(1);
          issued_d    = issued + LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_reg == '0) begin
            state_d = S_PULSE;
          end else begin
            gap_cnt_d = gap_reg;
            state_d   = S_GAP;
          end
        end
      end

      S_GAP: begin
        gap_cnt_d = gap_cnt - GAP_W'(1);
        if (abort_hit) begin
          state_d = S_DONE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_d = S_PULSE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dec_sequencer.sv
// Randomized bench for dec_sequencer against a per-burst schedule model.
// Exercises the abort port when DEC_SEQ_ABORT_EN is defined.
module tb_dec_sequencer;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP_W = 4;
  localparam int NONE = 99;

  logic             clock;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [GAP_W-1:0] gap;
  logic             zero;
  logic             dec;
  logic             busy;
  logic             done;
  logic             underflow;
  logic [LEN_W-1:0] issued;
`ifdef DEC_SEQ_ABORT_EN
  logic             abort;
`endif

  int n_vec;
  int n_err;
  int prev_issued;
  int prev_uf;

  dec_sequencer #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .gap       (gap),
    .zero      (zero),
    .dec       (dec),
    .busy      (busy),
    .done      (done),
    .underflow (underflow),
    .issued    (issued)
`ifdef DEC_SEQ_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_abort(input logic v);
`ifdef DEC_SEQ_ABORT_EN
    abort = v;
`else
    if (v) $display("abort requested in a build without the abort port");
`endif
  endtask

  // One burst: strobe k is due at relative cycle 1+k*(g+1); the burst stops
  // at the first of len exhausted, counter dry (index d) or abort (index a).
  task automatic run_burst(input int n, input int g, input int d, input int a);
    int stop, uf, done_c, k, cnt;
    bit is_due;
    stop = n;
    if (d < stop) stop = d;
    if (a < stop) stop = a;
    uf = (d < n && d < a) ? 1 : 0;
    if (stop == n) done_c = (n == 0) ? 1 : (1 + (n - 1) * (g + 1) + 1);
    else           done_c = 1 + stop * (g + 1) + 1;

    for (int c = 0; c <= done_c + 1; c++) begin
      @(posedge clock);
      #1;
      k = (c >= 1) ? (c - 1) / (g + 1) : 0;
      is_due = (c >= 1) && (((c - 1) % (g + 1)) == 0) && (k < n);
      set_abort(1'b0);
      if (c == 0) begin
        start = 1'b1;
        len   = LEN_W'(n);
        gap   = GAP_W'(g);
        zero  = 1'($urandom);
      end else begin
        start = (c <= done_c) ? 1'($urandom) : 1'b0;
        len   = LEN_W'($urandom);
        gap   = GAP_W'($urandom);
        zero  = is_due ? (k >= d) : 1'($urandom);
        if (is_due && k == a) set_abort(1'b1);
      end
      @(negedge clock);
      if (c <= 1)      cnt = 0;
      else begin
        cnt = (c - 2) / (g + 1) + 1;
        if (cnt > stop) cnt = stop;
      end
      check_eq("dec",  32'(dec),  32'(is_due && k < stop));
      check_eq("busy", 32'(busy), 32'(c >= 1 && c <= done_c));
      check_eq("done", 32'(done), 32'(c == done_c));
      check_eq("issued", 32'(issued), (c == 0) ? 32'(prev_issued) : 32'(cnt));
      check_eq("underflow", 32'(underflow),
               (c == 0) ? 32'(prev_uf) : 32'(uf == 1 && c > 1 + d * (g + 1)));
    end
    prev_issued = stop;
    prev_uf     = uf;
  endtask

  // Reset during the second gap of a len=4, gap=1 burst aborts it at once.
  task automatic run_reset_case();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clock);
      #1;
      start = (c == 0) || (c == 5 ? 1'b0 : 1'($urandom));
      len   = LEN_W'(4);
      gap   = GAP_W'(1);
      zero  = 1'b0;
      reset = (c == 4);
      @(negedge clock);
      if (c == 4) check_eq("rst_pre_issued", 32'(issued), 32'd2);
      if (c == 5) begin
        check_eq("rst_busy",   32'(busy),      32'd0);
        check_eq("rst_dec",    32'(dec),       32'd0);
        check_eq("rst_done",   32'(done),      32'd0);
        check_eq("rst_issued", 32'(issued),    32'd0);
        check_eq("rst_uf",     32'(underflow), 32'd0);
      end
    end
    prev_issued = 0;
    prev_uf     = 0;
  endtask

  initial begin
    int n, g, d, a;
    n_vec = 0;
    n_err = 0;
    prev_issued = 0;
    prev_uf = 0;
    reset = 1'b1;
    start = 1'b0;
    len   = '0;
    gap   = '0;
    zero  = 1'b0;
    set_abort(1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset_busy",   32'(busy),      32'd0);
    check_eq("reset_done",   32'(done),      32'd0);
    check_eq("reset_dec",    32'(dec),       32'd0);
    check_eq("reset_issued", 32'(issued),    32'd0);
    check_eq("reset_uf",     32'(underflow), 32'd0);
    reset = 1'b0;

    run_burst(3, 0, NONE, NONE);
    run_burst(2, 2, NONE, NONE);
    run_burst(5, 0, 2, NONE);
    run_burst(0, 3, NONE, NONE);
    run_burst(15, 0, NONE, NONE);
    run_burst(4, 1, 0, NONE);
    run_reset_case();
    run_burst(3, 2, NONE, NONE);
`ifdef DEC_SEQ_ABORT_EN
    run_burst(6, 1, NONE, 2);
    run_burst(4, 0, 1, 1);
`endif

    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 15);
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : NONE;
`ifdef DEC_SEQ_ABORT_EN
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : NONE;
`else
      a = NONE;
`endif
      run_burst(n, g, d, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
